// File: rtl/s5851a_i2c_slv_pkg.sv
// Shared types and constants for the S5851A-style I2C target.
// State encoding, SDA drive levels and default parameters.
package s5851a_i2c_slv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADR,
    ST_ADR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDAT,
    ST_WDAT_ACK,
    ST_RDAT,
    ST_MACK,
    ST_IGNORE
  } st_e;

  localparam logic SDA_ACK = 1'b0;
  localparam logic SDA_REL = 1'b1;

  localparam logic [6:0] DEF_SLV_ADR = 7'h48;
  localparam int         DEF_FLT     = 3;

endpackage

// File: rtl/s5851a_i2c_slv_in_flt.sv
// Pin synchroniser, stability filter and edge detector.
// Filtered level changes only after C_FLT stable cycles.
module s5851a_i2c_slv_in_flt #(
  parameter int C_FLT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic       s1;
  logic       s2;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      lvl  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == 4'(C_FLT - 1)) begin
        lvl  <= s2;
        rise <= s2;
        fall <= ~s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/s5851a_i2c_slv.sv
// I2C target with 8-bit register pointer and host register port.
// Writes strobe WT_REQ_o; reads serialise RD_DATs_i MSB first.
module s5851a_i2c_slv
  import s5851a_i2c_slv_pkg::*;
#(
  parameter logic [6:0] C_SLV_ADR = DEF_SLV_ADR,
  parameter int         C_FLT     = DEF_FLT
) (
  input  logic       CK_i,
  input  logic       SRST_i,
  input  logic       SCLI_i,
  input  logic       SDAI_i,
  output logic       SDAO_o,
  output logic       WT_REQ_o,
  output logic [7:0] WT_ADRs_o,
  output logic [7:0] WT_DATs_o,
  output logic [7:0] RD_ADRs_o,
  input  logic [7:0] RD_DATs_i,
  output logic       BUSY_o
);

  logic       scl, scl_r, scl_f;
  logic       sda, sda_r, sda_f;
  st_e        st;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic       rd;
  logic       ack_ph;
  logic [7:0] rx;
  logic       start;
  logic       stop;

  s5851a_i2c_slv_in_flt #(.C_FLT(C_FLT)) u_scl (
    .clk(CK_i), .rst(SRST_i), .pin(SCLI_i),
    .lvl(scl), .rise(scl_r), .fall(scl_f)
  );

  s5851a_i2c_slv_in_flt #(.C_FLT(C_FLT)) u_sda (
    .clk(CK_i), .rst(SRST_i), .pin(SDAI_i),
    .lvl(sda), .rise(sda_r), .fall(sda_f)
  );

  assign rx        = {shreg[6:0], sda};
  assign start     = sda_f & scl;
  assign stop      = sda_r & scl;
  assign RD_ADRs_o = ptr;

  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      st        <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rd        <= 1'b0;
      ack_ph    <= 1'b0;
      SDAO_o    <= SDA_REL;
      WT_REQ_o  <= 1'b0;
      WT_ADRs_o <= '0;
      WT_DATs_o <= '0;
      BUSY_o    <= 1'b0;
    end else begin
      WT_REQ_o <= 1'b0;
      if (start) begin
        st      <= ST_ADR;
        bit_cnt <= '0;
        ack_ph  <= 1'b0;
        SDAO_o  <= SDA_REL;
        BUSY_o  <= 1'b1;
      end else if (stop) begin
        st      <= ST_IDLE;
        bit_cnt <= '0;
        ack_ph  <= 1'b0;
        SDAO_o  <= SDA_REL;
        BUSY_o  <= 1'b0;
      end else begin
        unique case (st)
          ST_ADR: if (scl_r) begin
            shreg   <= rx;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rd <= sda;
              st <= (shreg[6:0] == C_SLV_ADR) ? ST_ADR_ACK : ST_IGNORE;
            end
          end
          // First fall drives ACK, second fall ends the ACK bit.
          ST_ADR_ACK: if (scl_f) begin
            if (!ack_ph) begin
              SDAO_o <= SDA_ACK;
              ack_ph <= 1'b1;
            end else begin
              ack_ph <= 1'b0;
              if (rd) begin
                shreg  <= RD_DATs_i;
                SDAO_o <= RD_DATs_i[7];
                st     <= ST_RDAT;
              end else begin
                SDAO_o <= SDA_REL;
                st     <= ST_SUB;
              end
            end
          end
          ST_SUB: if (scl_r) begin
            shreg   <= rx;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr <= rx;
              st  <= ST_SUB_ACK;
            end
          end
          ST_SUB_ACK, ST_WDAT_ACK: if (scl_f) begin
            if (!ack_ph) begin
              SDAO_o <= SDA_ACK;
              ack_ph <= 1'b1;
            end else begin
              ack_ph <= 1'b0;
              SDAO_o <= SDA_REL;
              st     <= ST_WDAT;
            end
          end
          ST_WDAT: if (scl_r) begin
            shreg   <= rx;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              WT_REQ_o  <= 1'b1;
              WT_ADRs_o <= ptr;
              WT_DATs_o <= rx;
              ptr       <= ptr + 8'd1;
              st        <= ST_WDAT_ACK;
            end
          end
          ST_RDAT: if (scl_f) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              SDAO_o <= SDA_REL;
              st     <= ST_MACK;
            end else begin
              SDAO_o <= shreg[6];
              shreg  <= {shreg[6:0], 1'b0};
            end
          end
          // ack_ph marks a master ACK awaiting the reload fall.
          ST_MACK: begin
            if (scl_r) begin
              if (sda) begin
                st <= ST_IGNORE;
              end else begin
                ptr    <= ptr + 8'd1;
                ack_ph <= 1'b1;
              end
            end else if (scl_f && ack_ph) begin
              ack_ph <= 1'b0;
              shreg  <= RD_DATs_i;
              SDAO_o <= RD_DATs_i[7];
              st     <= ST_RDAT;
            end
          end
          ST_IDLE, ST_IGNORE: ;
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/s5851a_i2c_slv.md
# s5851a_i2c_slv

I2C target (slave) responder that answers the S5851A-style register protocol issued by the team's I2C master sequencers. It decodes START/STOP and the 7-bit address, keeps an 8-bit register pointer, and hands written bytes to a host register bank through a one-cycle write strobe. On reads it serialises bytes fetched from that bank. It sits on the board-side SDA/SCL pins and doubles as the bus-functional sensor model in master benches.

## Interface
- C_SLV_ADR, 7'h48: 7-bit target address this block answers to.
- C_FLT, 3: glitch-filter length in CK cycles; a synchronised line must be stable for this many cycles before the filtered value changes. Legal range is 1..15.
- CK_i  in  1: system clock.
- SRST_i  in  1: reset, synchronous and active-high.
- SCLI_i  in  1: SCL pin sense. Asynchronous to CK_i.
- SDAI_i  in  1: SDA pin sense. Asynchronous to CK_i.
- SDAO_o  out  1: SDA open-drain control. 1 releases the line, 0 pulls it low.
- WT_REQ_o  out  1: one-cycle strobe for a received data byte.
- WT_ADRs_o  out  8: register address for the write; valid while WT_REQ_o is high.
- WT_DATs_o  out  8: write data; valid while WT_REQ_o is high.
- RD_ADRs_o  out  8: current register pointer, continuously driven.
- RD_DATs_i  in  8: register contents at RD_ADRs_o. Must be valid combinationally, or 1 cycle after RD_ADRs_o changes.
- BUSY_o  out  1: high from a detected START until a detected STOP.

## Operation
- **Input path**
  - 2-flop synchroniser on each of SCL and SDA, followed by the C_FLT stability filter.
  - Edge detection runs on the filtered signals only.
- **Bus conditions**
  - START or repeated START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL is high.
  - Either condition overrides every state, clears the bit counter and releases SDA.
  - START goes to ADR. STOP goes to IDLE.
- **Bit handling**
  - Data is sampled on the SCL rise and shifted MSB first.
  - SDAO_o changes only on the SCL fall.
- **States**
  - IDLE: wait for START.
  - ADR: collect 8 bits. If bits [7:1] equal C_SLV_ADR, go to ADR_ACK; otherwise go to IGNORE. Bit 0 is latched as RD.
  - ADR_ACK: drive 0 for the 9th bit. Then go to RDAT if RD=1, or to SUB if RD=0.
  - SUB: collect 8 bits and load them into the pointer, then go to SUB_ACK.
  - SUB_ACK: drive 0 for the 9th bit, then go to WDAT.
  - WDAT: collect 8 bits, then go to WDAT_ACK.
  - WDAT_ACK: drive 0 for the 9th bit. WT_REQ_o pulses with WT_ADRs_o = pointer and WT_DATs_o = byte. The pointer increments, then return to WDAT.
  - RDAT: at the SCL fall that ends the preceding ACK, capture RD_DATs_i into the shift register and drive bit 7. Drive bits 6..0 on the following falls, then go to MACK.
  - MACK: release SDA and sample the master's bit. On 0 (ACK): pointer increments and return to RDAT. On 1 (NACK): go to IGNORE with the pointer unchanged.
  - IGNORE: SDA stays released until START or STOP.
- **Pointer arithmetic**
  - 8-bit, wraps from 8'hFF to 8'h00.
  - Retained across transactions; this allows write-pointer, repeated START, then read.
  - Cleared only by reset.
- **Clock stretching**: none. SCL is never driven.

## Timing
- **Reset values**: SDAO_o=1, WT_REQ_o=0, WT_ADRs_o=0, WT_DATs_o=0, RD_ADRs_o=0, BUSY_o=0, state IDLE.
- **Filter latency**: a pin change becomes visible to the state machine 2+C_FLT cycles after it occurs.
- **Minimum bus timing**: SCL high and low phases of at least C_FLT+6 CK cycles each.
- **SDA drive**: SDAO_o updates in the cycle after the filtered SCL fall is detected. With the minimum SCL timing above, this gives hold of at least 3 CK cycles after the pin fall.
- **Write strobe**: WT_REQ_o asserts in the cycle after the filtered SCL rise of the 8th data bit and lasts exactly 1 cycle.
- **Read data**: RD_DATs_i is sampled in the same cycle bit 7 is driven. The pointer must already be stable at that point, which it is because it last changed at least one SCL phase earlier.
- **Reset mid-transfer**: takes effect on the next CK edge. SDA is released immediately and the block re-enters IDLE. The block then ignores the bus until a fresh START; any transfer in progress is not resumed.
- **Glitch rejection**: any input pulse shorter than C_FLT cycles is ignored.

## Structure
- **Shared package**: the state enumeration, the ACK/NACK level constants (ACK=0, release=1) and the default address.
- **Sub-module i2c_in_flt**: synchroniser plus stability filter plus rise/fall detection. Instantiated once for SCL and once for SDA; the main block holds the state machine, bit counter, shift register and pointer.

## Test plan
- **Write**: START, 0x90, 0x01, 0x60, STOP → ACK on all three bytes; one WT_REQ_o pulse with WT_ADRs_o=0x01 and WT_DATs_o=0x60; BUSY_o falls after STOP; RD_ADRs_o=0x02.
- **Pointer set then read**: START, 0x90, 0x00, repeated START, 0x91; RD_DATs_i model returns 0x19 at 0x00 and 0xA0 at 0x01; master ACKs the first byte and NACKs the second → SDA shows 0x19 then 0xA0; SDA released after the NACK; RD_ADRs_o=0x01.
- **Address mismatch**: START, 0x7C, 0x55, STOP → SDAO_o stays 1 throughout; no WT_REQ_o; pointer unchanged.
- **Wrap**: write sub-address 0xFF, then data 0x11 and 0x22 → WT_REQ_o at address 0xFF with 0x11, then at 0x00 with 0x22; RD_ADRs_o=0x01.
- **Reset mid-byte**: assert SRST_i during bit 4 of a read byte → SDAO_o=1 on the next cycle and no further drive; a later complete write to 0x90 succeeds.
- **Glitch**: 2-cycle SDA low pulse while SCL is high, with C_FLT=3 → no START detected, BUSY_o stays 0.
